// File: rtl/uart_alu_sequencer.sv
// Sequences a three-byte UART command frame (A, B, opcode) into the ALU operand
// registers, captures the ALU result and issues one UART TX request per frame.
module uart_alu_sequencer #(
  parameter int N_DATA         = 8,
  parameter int PARITY_CHECK   = 0,
  parameter int NB_OPERATION   = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_DROP        = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_DATA+PARITY_CHECK-1:0] i_rx_data,
  input  logic                           i_rx_done,
  input  logic                           i_tx_done,
  input  logic [N_DATA-1:0]              i_alu_data,
  output logic [N_DATA-1:0]              o_alu_data_a,
  output logic [N_DATA-1:0]              o_alu_data_b,
  output logic [NB_OPERATION-1:0]        o_alu_data_op,
  output logic [N_DATA-1:0]              o_tx_data,
  output logic                           o_tx_start,
  output logic                           o_busy,
  output logic                           o_timeout,
  output logic                           o_parity_err,
  output logic [NB_DROP-1:0]             o_drop_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, TX_START, TX_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TW-1:0]     r_tcnt;
  logic [N_DATA-1:0] w_data;
  logic              w_parity_ok;
  logic              w_wait_state;
  logic              w_accept;
  logic              w_perr;
  logic              w_expire;

  assign w_data = i_rx_data[N_DATA-1:0];

  // Even parity over the whole word, parity bit included.
  generate
    if (PARITY_CHECK != 0) begin : g_parity
      assign w_parity_ok = ~^i_rx_data;
    end else begin : g_no_parity
      assign w_parity_ok = 1'b1;
    end
  endgenerate

  assign w_wait_state = (r_state == WAIT_A) || (r_state == WAIT_B) || (r_state == WAIT_OP);
  assign w_accept     = i_rx_done && w_wait_state && w_parity_ok;
  assign w_perr       = i_rx_done && w_wait_state && !w_parity_ok;
  assign w_expire     = ((r_state == WAIT_B) || (r_state == WAIT_OP)) && !i_rx_done &&
                        (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= WAIT_A;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_A:   if (w_accept) w_next = WAIT_B;
      WAIT_B:   if (w_accept) w_next = WAIT_OP;
                else if (w_perr || w_expire) w_next = WAIT_A;
      WAIT_OP:  if (w_accept) w_next = EXEC;
                else if (w_perr || w_expire) w_next = WAIT_A;
      EXEC:     w_next = TX_START;
      TX_START: w_next = TX_WAIT;
      TX_WAIT:  if (i_tx_done) w_next = WAIT_A;
      default:  w_next = WAIT_A;
    endcase
  end

  always_comb begin
    o_busy     = (r_state == EXEC) || (r_state == TX_START) || (r_state == TX_WAIT);
    o_tx_start = (r_state == TX_START);
  end

  // Operand capture, result capture, event pulses and drop accounting.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_alu_data_a  <= '0;
      o_alu_data_b  <= '0;
      o_alu_data_op <= '0;
      o_tx_data     <= '0;
      o_timeout     <= 1'b0;
      o_parity_err  <= 1'b0;
      o_drop_count  <= '0;
      r_tcnt        <= '0;
    end else begin
      o_timeout    <= w_expire;
      o_parity_err <= w_perr;
      if (w_accept) begin
        case (r_state)
          WAIT_A:  o_alu_data_a  <= w_data;
          WAIT_B:  o_alu_data_b  <= w_data;
          WAIT_OP: o_alu_data_op <= w_data[NB_OPERATION-1:0];
          default: ;
        endcase
      end
      if (r_state == EXEC) o_tx_data <= i_alu_data;
      if (i_rx_done && !w_wait_state && (o_drop_count != '1))
        o_drop_count <= o_drop_count + 1'b1;
      if (w_accept || (w_next == WAIT_A))
        r_tcnt <= '0;
      else if ((r_state == WAIT_B) || (r_state == WAIT_OP))
        r_tcnt <= r_tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: directed frames, timeout, parity,
// drop saturation and reset scenarios plus randomized frames against a frame-level model.
module tb_uart_alu_sequencer;

  localparam int N_DATA         = 8;
  localparam int PARITY_CHECK   = 1;
  localparam int NB_OPERATION   = 6;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int NB_DROP        = 2;
  localparam int DROP_MAX       = (1 << NB_DROP) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  rxData;
  logic        rxDone;
  logic        txDone;
  logic [7:0]  aluData;
  logic [7:0]  aluA;
  logic [7:0]  aluB;
  logic [5:0]  aluOp;
  logic [7:0]  txData;
  logic        txStart;
  logic        busy;
  logic        timeoutPulse;
  logic        parityErr;
  logic [1:0]  dropCount;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] modelA, modelB, modelRes;
  logic [5:0] modelOp;
  int         modelDrop;

  always #5 clk = ~clk;

  uart_alu_sequencer #(
    .N_DATA(N_DATA), .PARITY_CHECK(PARITY_CHECK), .NB_OPERATION(NB_OPERATION),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .NB_DROP(NB_DROP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rxData), .i_rx_done(rxDone),
    .i_tx_done(txDone), .i_alu_data(aluData),
    .o_alu_data_a(aluA), .o_alu_data_b(aluB), .o_alu_data_op(aluOp),
    .o_tx_data(txData), .o_tx_start(txStart), .o_busy(busy),
    .o_timeout(timeoutPulse), .o_parity_err(parityErr), .o_drop_count(dropCount)
  );

  // Simple combinational ALU standing in for the real one.
  function automatic logic [7:0] aluRef(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  always_comb aluData = aluRef(aluA, aluB, aluOp);

  function automatic logic [8:0] goodWord(input logic [7:0] d);
    return {^d, d};
  endfunction

  function automatic logic [8:0] badWord(input logic [7:0] d);
    return {~(^d), d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [8:0] word, input logic done, input logic txd);
    rxData = word;
    rxDone = done;
    txDone = txd;
    step();
    rxDone = 1'b0;
    txDone = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(9'h000, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, " a"}, 32'(aluA), 32'(modelA));
    checkOutput({tag, " b"}, 32'(aluB), 32'(modelB));
    checkOutput({tag, " op"}, 32'(aluOp), 32'(modelOp));
    checkOutput({tag, " drop"}, 32'(dropCount), 32'(modelDrop));
  endtask

  task automatic checkFlags(input string tag, input logic expBusy, input logic expStart,
                            input logic expTo, input logic expPerr);
    checkOutput({tag, " busy"}, 32'(busy), 32'(expBusy));
    checkOutput({tag, " tx_start"}, 32'(txStart), 32'(expStart));
    checkOutput({tag, " timeout"}, 32'(timeoutPulse), 32'(expTo));
    checkOutput({tag, " parity_err"}, 32'(parityErr), 32'(expPerr));
  endtask

  task automatic doReset();
    rst = 1'b0;
    step();
    modelA = '0; modelB = '0; modelOp = '0; modelDrop = 0; modelRes = '0;
    checkRegs("reset");
    checkFlags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset tx_data", 32'(txData), 32'h0);
    rst = 1'b1;
  endtask

  // Full frame: three bytes, result pulse, optional drops, then TX completion.
  task automatic runFrame(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] opByte, input int txDelay, input int drops);
    applyStimulus(goodWord(a), 1'b1, 1'b0);
    modelA = a;
    checkRegs({tag, " after A"});
    checkFlags({tag, " after A"}, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(goodWord(b), 1'b1, 1'b0);
    modelB = b;
    checkRegs({tag, " after B"});
    applyStimulus(goodWord(opByte), 1'b1, 1'b0);
    modelOp = opByte[5:0];
    modelRes = aluRef(modelA, modelB, modelOp);
    checkRegs({tag, " after OP"});
    checkFlags({tag, " exec"}, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    checkFlags({tag, " tx_start"}, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput({tag, " tx_data"}, 32'(txData), 32'(modelRes));
    idle();
    checkFlags({tag, " tx_wait"}, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < drops; i++) begin
      applyStimulus((($urandom_range(0, 1) == 0) ? badWord(8'($urandom)) : goodWord(8'($urandom))),
                    1'b1, 1'b0);
      modelDrop = (modelDrop < DROP_MAX) ? modelDrop + 1 : DROP_MAX;
      checkRegs({tag, " drop"});
      checkFlags({tag, " drop"}, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < txDelay; i++) begin
      idle();
      checkFlags({tag, " hold"}, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(9'h000, 1'b0, 1'b1);
    checkFlags({tag, " done"}, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " tx_data held"}, 32'(txData), 32'(modelRes));
  endtask

  logic [5:0] opList [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};

  initial begin
    rst = 1'b0; rxData = '0; rxDone = 1'b0; txDone = 1'b0;
    step();
    doReset();

    // Basic ADD frame
    runFrame("add", 8'h05, 8'h03, 8'h20, 3, 0);
    checkOutput("add result", 32'(txData), 32'h08);

    // Timeout after two bytes
    applyStimulus(goodWord(8'h11), 1'b1, 1'b0);
    applyStimulus(goodWord(8'h22), 1'b1, 1'b0);
    modelA = 8'h11; modelB = 8'h22;
    for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
      idle();
      checkFlags("to pending", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle();
    checkFlags("to expire", 1'b0, 1'b0, 1'b1, 1'b0);
    checkRegs("to expire");
    idle();
    checkFlags("to after", 1'b0, 1'b0, 1'b0, 1'b0);
    runFrame("post-to", 8'h01, 8'h01, 8'h20, 1, 0);
    checkOutput("post-to result", 32'(txData), 32'h02);

    // Drops during TX_WAIT and saturation at the two-bit limit
    runFrame("drop3", 8'h40, 8'h02, 8'h22, 2, 3);
    checkOutput("drop3 count", 32'(dropCount), 32'd3);
    runFrame("drop5", 8'h0F, 8'hF0, 8'h25, 0, 2);
    checkOutput("drop5 saturated", 32'(dropCount), 32'd3);

    // Parity rejection in WAIT_B and WAIT_A
    applyStimulus(9'h005, 1'b1, 1'b0);
    modelA = 8'h05;
    checkFlags("par A ok", 1'b0, 1'b0, 1'b0, 1'b0);
    checkRegs("par A ok");
    applyStimulus(9'h103, 1'b1, 1'b0);
    checkFlags("par B bad", 1'b0, 1'b0, 1'b0, 1'b1);
    checkRegs("par B bad");
    idle();
    checkFlags("par clear", 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(badWord(8'h77), 1'b1, 1'b0);
    checkFlags("par A bad", 1'b0, 1'b0, 1'b0, 1'b1);
    checkRegs("par A bad");
    runFrame("par resend", 8'h33, 8'h0C, 8'h26, 1, 0);

    // Opcode arriving on the expiry cycle wins over the timeout
    applyStimulus(goodWord(8'h09), 1'b1, 1'b0);
    applyStimulus(goodWord(8'h04), 1'b1, 1'b0);
    modelA = 8'h09; modelB = 8'h04;
    for (int i = 1; i < TIMEOUT_CYCLES; i++) idle();
    applyStimulus(goodWord(8'h22), 1'b1, 1'b0);
    modelOp = 6'h22;
    checkFlags("coinc exec", 1'b1, 1'b0, 1'b0, 1'b0);
    checkRegs("coinc");
    idle();
    checkFlags("coinc tx_start", 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("coinc tx_data", 32'(txData), 32'h05);
    applyStimulus(9'h000, 1'b0, 1'b1);
    applyStimulus(9'h000, 1'b0, 1'b1);
    checkFlags("coinc done", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while in TX_WAIT abandons the frame
    applyStimulus(goodWord(8'hA0), 1'b1, 1'b0);
    applyStimulus(goodWord(8'h0A), 1'b1, 1'b0);
    applyStimulus(goodWord(8'h25), 1'b1, 1'b0);
    applyStimulus(9'h1FF, 1'b1, 1'b0);
    idle();
    idle();
    doReset();
    applyStimulus(9'h000, 1'b0, 1'b1);
    checkFlags("rst tx_done", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkFlags("rst quiet", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkRegs("rst quiet");

    // Randomized frames
    for (int n = 0; n < 12; n++) begin
      runFrame("rand", 8'($urandom), 8'($urandom),
               {2'($urandom_range(0, 3)), opList[$urandom_range(0, 5)]},
               $urandom_range(0, 4), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
